mul_share_ctrl: RTL and testbench

- Round-robin scheduler sharing one sequential fixed-point multiplier among N_REQ requesters (ODE stage units).
- Latches the winner's operands and drives the multiplier start/finish handshake.
- Routes result and overflow back to the winner.
- Sits between the solver stages and the single multiplier instance.

---
 rtl/mul_share_pkg.sv | 11 +
 rtl/mul_share_ctrl_rr_arbiter.sv | 32 +++
 rtl/mul_share_ctrl.sv | 125 ++++++++++++
 tb/tb_mul_share_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared constants and state encoding for mul_share_ctrl
package mul_share_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// rtl/mul_share_ctrl_rr_arbiter.sv - rotate-priority pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     sum;

  // Rotating the doubled vector puts ptr at bit 0 so the lowest set bit is the winner.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    offset = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) offset = IDX_W'(j);
    end
  end

  assign sum     = {1'b0, ptr} + {1'b0, offset};
  assign winner  = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ)) : sum[IDX_W-1:0];
  assign any_req = |req;

endmodule

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin sharing of one sequential multiplier among N_REQ requesters
// Optional watchdog on the ISSUE phase: MUL_SHARE_TIMEOUT_EN.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_overflow,
  output logic               resp_timeout,
  output logic               busy,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start,
  input  logic [WIDTH-1:0]   mul_result,
  input  logic               mul_overflow,
  input  logic               mul_finish
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] arb_win;
  logic             any_req;
  logic             first;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .winner  (arb_win),
    .any_req (any_req)
  );

  assign busy = (state != ST_IDLE);

`ifdef MUL_SHARE_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] tcnt;
`else
  assign resp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      win           <= '0;
      first         <= 1'b0;
      gnt           <= '0;
      resp_valid    <= '0;
      resp_result   <= '0;
      resp_overflow <= 1'b0;
      mul_a         <= '0;
      mul_b         <= '0;
      mul_start     <= 1'b0;
`ifdef MUL_SHARE_TIMEOUT_EN
      resp_timeout  <= 1'b0;
      tcnt          <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            win       <= arb_win;
            gnt       <= ONE_HOT0 << arb_win;
            mul_a     <= req_a[arb_win*WIDTH +: WIDTH];
            mul_b     <= req_b[arb_win*WIDTH +: WIDTH];
            mul_start <= 1'b1;
            first     <= 1'b1;
            state     <= ST_ISSUE;
`ifdef MUL_SHARE_TIMEOUT_EN
            tcnt      <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          first <= 1'b0;
          // A finish seen in the first ISSUE cycle may be left over from the previous operation.
          if (mul_finish && !first) begin
            resp_result   <= mul_result;
            resp_overflow <= mul_overflow;
            resp_valid    <= ONE_HOT0 << win;
            mul_start     <= 1'b0;
            state         <= ST_RESP;
`ifdef MUL_SHARE_TIMEOUT_EN
            resp_timeout  <= 1'b0;
          end else if (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
            resp_result   <= '0;
            resp_overflow <= 1'b1;
            resp_timeout  <= 1'b1;
            resp_valid    <= ONE_HOT0 << win;
            mul_start     <= 1'b0;
            state         <= ST_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          resp_valid <= '0;
          gnt        <= '0;
          rr_ptr     <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - scoreboard bench for mul_share_ctrl with a stub sequential multiplier
module tb_mul_share_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  gnt, resp_valid;
  logic [15:0] resp_result, mul_a, mul_b, mul_result;
  logic        resp_overflow, resp_timeout, busy, mul_start, mul_overflow, mul_finish;

  logic        stale = 1'b0;
  logic        dead  = 1'b0;
  logic [3:0]  scnt;
  logic        sfin;
  logic [31:0] prod;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        ovf;
    logic        tmo;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mul_share_ctrl dut (
    .clk (clk), .rst (rst), .req (req), .req_a (req_a), .req_b (req_b),
    .gnt (gnt), .resp_valid (resp_valid), .resp_result (resp_result),
    .resp_overflow (resp_overflow), .resp_timeout (resp_timeout), .busy (busy),
    .mul_a (mul_a), .mul_b (mul_b), .mul_start (mul_start),
    .mul_result (mul_result), .mul_overflow (mul_overflow), .mul_finish (mul_finish)
  );

  // Stub multiplier: finish rises in the 7th cycle of mul_start, product is combinational.
  assign prod         = {16'h0, mul_a} * {16'h0, mul_b};
  assign mul_result   = prod[15:0];
  assign mul_overflow = |prod[31:16];
  assign mul_finish   = sfin | stale;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt <= '0;
      sfin <= 1'b0;
    end else if (!mul_start) begin
      scnt <= '0;
      sfin <= 1'b0;
    end else begin
      scnt <= scnt + 1'b1;
      sfin <= (scnt == 4'd5) && !dead;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int idx, input logic [15:0] res, input logic ovf, input logic tmo);
    exp_t e;
    e.idx = idx; e.res = res; e.ovf = ovf; e.tmo = tmo;
    return e;
  endfunction

  task automatic set_ops(input int idx, input logic [15:0] a, input logic [15:0] b);
    req_a[idx*16 +: 16] = a;
    req_b[idx*16 +: 16] = b;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_gnt"}, {28'h0, gnt}, 32'h0);
    chk({tag, "_resp_valid"}, {28'h0, resp_valid}, 32'h0);
    chk({tag, "_busy_start"}, {30'h0, busy, mul_start}, 32'h0);
    chk({tag, "_mul_ab"}, {mul_a, mul_b}, 32'h0);
    chk({tag, "_resp"}, {14'h0, resp_result, resp_overflow, resp_timeout}, 32'h0);
  endtask

  task automatic run_one(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic eo, input logic et,
                         input int exp_lat, input bit stale_en, input bit drop_early);
    int cyc;
    set_ops(idx, a, b);
    sb.push_back(mk(idx, er, eo, et));
    stale    = stale_en;
    req[idx] = 1'b1;
    cyc = 0;
    while (cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        chk("gnt_first", {28'h0, gnt}, 32'(4'b0001 << idx));
        chk("start_ab", {15'h0, mul_start, mul_a}, {15'h0, 1'b1, a});
      end
      if (cyc == 2) begin
        stale = 1'b0;
        if (drop_early) req[idx] = 1'b0;
      end
      if (resp_valid[idx]) break;
    end
    req[idx] = 1'b0;
    chk("latency", cyc, exp_lat);
  endtask

  task automatic wait_n(input int n, input logic [3:0] keep);
    int got, cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (|resp_valid) begin
        got++;
        req = req & ~(resp_valid & ~keep);
      end
    end
    req = '0;
    chk("svc_count", got, n);
  endtask

  // Monitor: pops the scoreboard on every response and guards grant one-hotness.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && busy) begin
        vectors++;
        if (!$onehot(gnt)) begin
          errors++;
          $display("FAIL gnt_onehot: got %b expected one-hot", gnt);
        end
      end
      if (rst && |resp_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid %b expected none", resp_valid);
        end else begin
          e = sb.pop_front();
          chk("resp_idx", {28'h0, resp_valid}, 32'(4'b0001 << e.idx));
          chk("resp_result", {16'h0, resp_result}, {16'h0, e.res});
          chk("resp_flags", {30'h0, resp_overflow, resp_timeout}, {30'h0, e.ovf, e.tmo});
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 check_idle_zero("reset");
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    run_one(0, 16'h0003, 16'h0004, 16'h000C, 1'b0, 1'b0, 8, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk("result_hold", {16'h0, resp_result}, 32'h0000_000C);

    // Contention from rr_ptr=0: order 0,1,2,3,0.
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 16'(i + 1), 16'(16 * (i + 1)));
    sb.push_back(mk(0, 16'h0010, 1'b0, 1'b0));
    sb.push_back(mk(1, 16'h0040, 1'b0, 1'b0));
    sb.push_back(mk(2, 16'h0090, 1'b0, 1'b0));
    sb.push_back(mk(3, 16'h0100, 1'b0, 1'b0));
    sb.push_back(mk(0, 16'h0010, 1'b0, 1'b0));
    req = 4'b1111;
    wait_n(5, 4'b1111);
    repeat (2) @(negedge clk);

    // Serving 1 moves rr_ptr to 2; then 3 must precede 1.
    run_one(1, 16'h0011, 16'h0003, 16'h0033, 1'b0, 1'b0, 8, 0, 0);
    repeat (2) @(negedge clk);
    set_ops(3, 16'h0101, 16'h00FF);
    set_ops(1, 16'h8000, 16'h0002);
    sb.push_back(mk(3, 16'hFFFF, 1'b0, 1'b0));
    sb.push_back(mk(1, 16'h0000, 1'b1, 1'b0));
    req = 4'b1010;
    wait_n(2, 4'b0000);
    repeat (2) @(negedge clk);

    run_one(2, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 8, 0, 0);
    repeat (2) @(negedge clk);
    run_one(2, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 8, 0, 0);
    repeat (2) @(negedge clk);

    // Reset mid-ISSUE: silent abort, rr_ptr back to 0.
    set_ops(3, 16'h0002, 16'h0003);
    req = 4'b1000;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1 check_idle_zero("mid_reset");
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (20) begin @(posedge clk); #1; if (|resp_valid) n++; end
    chk("no_resp_after_reset", n, 0);
    set_ops(0, 16'h0007, 16'h0009);
    set_ops(3, 16'h1000, 16'h0010);
    sb.push_back(mk(0, 16'h003F, 1'b0, 1'b0));
    sb.push_back(mk(3, 16'h0000, 1'b1, 1'b0));
    @(negedge clk) req = 4'b1001;
    wait_n(2, 4'b0000);
    repeat (2) @(negedge clk);

    run_one(0, 16'h0005, 16'h0007, 16'h0023, 1'b0, 1'b0, 8, 1, 0);
    repeat (2) @(negedge clk);
    run_one(3, 16'h1234, 16'h0002, 16'h2468, 1'b0, 1'b0, 8, 0, 1);
    repeat (2) @(negedge clk);

`ifdef MUL_SHARE_TIMEOUT_EN
    dead = 1'b1;
    run_one(1, 16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b1, 65, 0, 0);
    dead = 1'b0;
    repeat (2) @(negedge clk);
    run_one(2, 16'h0009, 16'h0009, 16'h0051, 1'b0, 1'b0, 8, 0, 0);
    repeat (2) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
